phase_clockgen: RTL and testbench

Parametrised two-phase clock generator for the MCS-4 emulation, the successor to the fixed free-running divider. It derives clk1/clk2 from sysclk with timing set by parameters, and adds advanced external copies for the off-FPGA clock driver. It also adds a run/halt/single-step controller that starts and stops the clocks only on instruction-cycle boundaries, plus a subcycle (phase) index. It sits at the top level and feeds every MCS-4 chip model and the external CPU socket.

---
 rtl/phase_clockgen_pkg.sv | 23 ++
 rtl/phase_clockgen_clkpulse.sv | 31 +++
 rtl/phase_clockgen.sv | 134 +++++++++++++
 tb/tb_phase_clockgen.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/phase_clockgen_pkg.sv
// Shared types and helpers for the MCS-4 two-phase clock generator.
// Holds the controller state encoding and the elaboration-time clog2.
package phase_clockgen_pkg;

   typedef enum logic [1:0] {
      ST_HALT = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/phase_clockgen_clkpulse.sv
// Registered set/clear pulse generator keyed on the phase counter.
// Rises on the edge where cnt==START and falls on the edge where cnt==END.
module phase_clockgen_clkpulse #(
   parameter int START = 0,
   parameter int END   = 1,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] cnt,
   output logic         pulse
);

   localparam logic [W-1:0] START_W = W'(START);
   localparam logic [W-1:0] END_W   = W'(END);

   // Pulse register: set/clear on counter match, held otherwise
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pulse <= 1'b0;
      end else if (en && (cnt == START_W)) begin
         pulse <= 1'b1;
      end else if (en && (cnt == END_W)) begin
         pulse <= 1'b0;
      end else begin
         pulse <= pulse;
      end
   end

endmodule

// File: rtl/phase_clockgen.sv
// Parametrised MCS-4 two-phase clock generator with run/halt/single-step
// control that starts and stops only on instruction-cycle boundaries.
module phase_clockgen
   import phase_clockgen_pkg::*;
#(
   parameter int SYSCLK_TCY   = 20,
   parameter int TPW          = 400,
   parameter int TD1          = 400,
   parameter int TD2          = 200,
   parameter int EXT_CLK_PROP = 0
) (
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic       run,
   input  logic       step,
   output logic       clk1,
   output logic       clk2,
   output logic       clk1_ext,
   output logic       clk2_ext,
   output logic [2:0] phase,
   output logic       phase_strobe,
   output logic       running
);

   localparam int TCY        = TD1 + TPW + TD2 + TPW;
   localparam int CMAX       = TCY / SYSCLK_TCY - 1;
   localparam int W          = clog2(CMAX + 1);
   localparam int S_TPW      = TPW / SYSCLK_TCY;
   localparam int S_TD1      = TD1 / SYSCLK_TCY;
   localparam int S_TD2      = TD2 / SYSCLK_TCY;
   localparam int CLK1_START = S_TD2 - 1;
   localparam int CLK1_END   = CLK1_START + S_TPW;
   localparam int CLK2_START = CLK1_END + S_TD1;
   localparam int CLK2_END   = CLK2_START + S_TPW;

   localparam logic [W-1:0] CMAX_W = W'(CMAX);

   if (((TPW % SYSCLK_TCY) != 0) || ((TD1 % SYSCLK_TCY) != 0) ||
       ((TD2 % SYSCLK_TCY) != 0)) begin : g_bad_multiple
      $fatal(1, "phase_clockgen: TPW/TD1/TD2 must be multiples of SYSCLK_TCY");
   end
   if (S_TD2 < 1) begin : g_bad_td2
      $fatal(1, "phase_clockgen: TD2 must be at least one sysclk period");
   end
   if ((EXT_CLK_PROP < 0) || (EXT_CLK_PROP > CLK1_START)) begin : g_bad_ext
      $fatal(1, "phase_clockgen: EXT_CLK_PROP out of range");
   end

   state_t         state_r;
   logic [W-1:0]   clockdiv_r;
   logic           active;
   logic           at_max;
   logic           boundary;

   assign active   = (state_r != ST_HALT);
   assign at_max   = (clockdiv_r == CMAX_W);
   assign boundary = at_max && (phase == 3'd7);

   // Controller FSM plus subcycle counters; counters idle at zero in HALT
   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         state_r      <= ST_HALT;
         clockdiv_r   <= '0;
         phase        <= 3'd0;
         phase_strobe <= 1'b0;
         running      <= 1'b0;
      end else begin
         phase_strobe <= active && (clockdiv_r == '0);
         case (state_r)
            ST_HALT: begin
               clockdiv_r <= '0;
               phase      <= 3'd0;
               if (run) begin
                  state_r <= ST_RUN;
                  running <= 1'b1;
               end else if (step) begin
                  state_r <= ST_STEP;
                  running <= 1'b1;
               end else begin
                  state_r <= ST_HALT;
                  running <= 1'b0;
               end
            end
            ST_RUN, ST_STEP: begin
               if (at_max) begin
                  clockdiv_r <= '0;
                  phase      <= phase + 3'd1;
               end else begin
                  clockdiv_r <= clockdiv_r + W'(1);
                  phase      <= phase;
               end
               // Only the instruction-cycle boundary may change the state
               if (boundary && run) begin
                  state_r <= ST_RUN;
                  running <= 1'b1;
               end else if (boundary) begin
                  state_r <= ST_HALT;
                  running <= 1'b0;
               end else begin
                  state_r <= state_r;
                  running <= 1'b1;
               end
            end
            default: begin
               state_r    <= ST_HALT;
               clockdiv_r <= '0;
               phase      <= 3'd0;
               running    <= 1'b0;
            end
         endcase
      end
   end

   phase_clockgen_clkpulse #(.START(CLK1_START), .END(CLK1_END), .W(W)) u_clk1 (
      .clk(sysclk), .rst_n(rst_n), .en(active), .cnt(clockdiv_r), .pulse(clk1)
   );

   phase_clockgen_clkpulse #(.START(CLK2_START), .END(CLK2_END), .W(W)) u_clk2 (
      .clk(sysclk), .rst_n(rst_n), .en(active), .cnt(clockdiv_r), .pulse(clk2)
   );

   phase_clockgen_clkpulse #(
      .START(CLK1_START - EXT_CLK_PROP), .END(CLK1_END - EXT_CLK_PROP), .W(W)
   ) u_clk1_ext (
      .clk(sysclk), .rst_n(rst_n), .en(active), .cnt(clockdiv_r), .pulse(clk1_ext)
   );

   phase_clockgen_clkpulse #(
      .START(CLK2_START - EXT_CLK_PROP), .END(CLK2_END - EXT_CLK_PROP), .W(W)
   ) u_clk2_ext (
      .clk(sysclk), .rst_n(rst_n), .en(active), .cnt(clockdiv_r), .pulse(clk2_ext)
   );

endmodule

// File: tb/tb_phase_clockgen.sv
// Randomized bench for phase_clockgen: two instances (ext advance 0 and 2)
// compared every sysclk against a position-in-instruction-cycle model.
module tb_phase_clockgen;

   localparam int SYS  = 20;
   localparam int TCYC = (400 + 400 + 200 + 400) / SYS;  // sysclk per phase
   localparam int ICYC = TCYC * 8;                        // sysclk per instruction
   localparam int C1S  = 200 / SYS - 1;
   localparam int C1E  = C1S + 400 / SYS;
   localparam int C2S  = C1E + 400 / SYS;
   localparam int C2E  = C2S + 400 / SYS;

   logic sysclk = 1'b0;
   logic rst_n  = 1'b0;
   logic run    = 1'b0;
   logic step   = 1'b0;

   logic       clk1_0, clk2_0, clk1e_0, clk2e_0, strobe_0, running_0;
   logic [2:0] phase_0;
   logic       clk1_2, clk2_2, clk1e_2, clk2e_2, strobe_2, running_2;
   logic [2:0] phase_2;

   logic [8:0] obs0, obs2, exp0, exp2;
   assign obs0 = {clk1_0, clk2_0, clk1e_0, clk2e_0, running_0, strobe_0, phase_0};
   assign obs2 = {clk1_2, clk2_2, clk1e_2, clk2e_2, running_2, strobe_2, phase_2};

   int checks   = 0;
   int failures = 0;

   bit m_active = 1'b0;
   int m_k      = 0;

   always #5 sysclk = ~sysclk;

   phase_clockgen #(.EXT_CLK_PROP(0)) dut0 (
      .sysclk(sysclk), .rst_n(rst_n), .run(run), .step(step),
      .clk1(clk1_0), .clk2(clk2_0), .clk1_ext(clk1e_0), .clk2_ext(clk2e_0),
      .phase(phase_0), .phase_strobe(strobe_0), .running(running_0)
   );

   phase_clockgen #(.EXT_CLK_PROP(2)) dut2 (
      .sysclk(sysclk), .rst_n(rst_n), .run(run), .step(step),
      .clk1(clk1_2), .clk2(clk2_2), .clk1_ext(clk1e_2), .clk2_ext(clk2e_2),
      .phase(phase_2), .phase_strobe(strobe_2), .running(running_2)
   );

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks = checks + 1;
      if (obs !== expv) begin
         failures = failures + 1;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
      end
   endtask

   // Model: m_k is the position of the next edge inside the instruction cycle.
   task automatic model_edge();
      int d;
      logic c1, c2, e1b, e2b, rn, sb;
      logic [2:0] ph;
      c1 = 1'b0; c2 = 1'b0; e1b = 1'b0; e2b = 1'b0; rn = 1'b0; sb = 1'b0; ph = 3'd0;
      if (!rst_n) begin
         m_active = 1'b0;
      end else if (!m_active) begin
         if (run || step) begin
            m_active = 1'b1;
            m_k = 0;
            rn = 1'b1;
         end
      end else begin
         d   = m_k % TCYC;
         c1  = (d >= C1S) && (d < C1E);
         c2  = (d >= C2S) && (d < C2E);
         e1b = (d >= C1S - 2) && (d < C1E - 2);
         e2b = (d >= C2S - 2) && (d < C2E - 2);
         sb  = (d == 0);
         if (m_k == ICYC - 1) begin
            if (run) begin
               m_k = 0;
               rn = 1'b1;
            end else begin
               m_active = 1'b0;
            end
         end else begin
            m_k = m_k + 1;
            rn = 1'b1;
            ph = 3'(m_k / TCYC);
         end
      end
      exp0 = {c1, c2, c1, c2, rn, sb, ph};
      exp2 = {c1, c2, e1b, e2b, rn, sb, ph};
   endtask

   task automatic tick();
      @(posedge sysclk);
      model_edge();
      @(negedge sysclk);
      check_eq("outs_ext0", 16'(obs0), 16'(exp0));
      check_eq("outs_ext2", 16'(obs2), 16'(exp2));
   endtask

   initial begin
      int n;
      int r1, r2;
      logic p1, p2;

      // Reset held with run=1
      rst_n = 1'b0; run = 1'b1; step = 1'b0;
      repeat (5) tick();
      rst_n = 1'b1; run = 1'b0;
      repeat (3) tick();

      // Start, drop run during phase 3, count edges until halted
      run = 1'b1;
      tick();
      n = 0;
      for (int i = 0; i < 800; i++) begin
         tick();
         n = n + 1;
         if (run && (phase_0 == 3'd3)) run = 1'b0;
         if (!running_0) break;
      end
      check_eq("halt_latency", 16'(n), 16'(ICYC));

      // Free run with step noise, then halt
      run = 1'b1;
      for (int i = 0; i < 1000 + int'($urandom_range(0, 700)); i++) begin
         step = ($urandom_range(0, 49) == 0);
         tick();
      end
      step = 1'b0; run = 1'b0;
      for (int i = 0; i < 700; i++) begin
         tick();
         if (!running_0) break;
      end
      repeat (4) tick();

      // Single step: count clock rises
      step = 1'b1;
      tick();
      step = 1'b0;
      r1 = 0; r2 = 0; p1 = clk1_0; p2 = clk2_2;
      for (int i = 0; i < ICYC + 40; i++) begin
         tick();
         if (clk1_0 && !p1) r1 = r1 + 1;
         if (clk2_2 && !p2) r2 = r2 + 1;
         p1 = clk1_0; p2 = clk2_2;
      end
      check_eq("step_clk1_pulses", 16'(r1), 16'd8);
      check_eq("step_clk2_pulses", 16'(r2), 16'd8);

      // Random run/step/reset activity
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) run = ~run;
         step  = ($urandom_range(0, 29) == 0);
         rst_n = ($urandom_range(0, 999) != 0);
         tick();
      end
      step = 1'b0;

      // Mid-pulse reset then restart latency
      rst_n = 1'b0; run = 1'b0;
      tick();
      rst_n = 1'b1; run = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (clk1_0) break;
      end
      rst_n = 1'b0;
      tick();
      check_eq("midpulse_clk1", 16'(clk1_0), 16'd0);
      check_eq("midpulse_running", 16'(running_0), 16'd0);
      rst_n = 1'b1;
      tick();
      n = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         n = n + 1;
         if (clk1_0) break;
      end
      check_eq("restart_clk1_latency", 16'(n), 16'(C1S + 1));
      repeat (20) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
